// File: rtl/axis_write_data_strb.sv
// AXI write-data engine: buffers an upstream word stream and packs WIDTH_RATIO words per W beat.
// Build option AXIS_WRITE_DATA_STRB_STATUS_EN adds beat_count / burst_count status outputs.
module axis_write_data_strb_lane #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    held_i,
  input  logic                    head_i,
  input  logic [DATA_WIDTH-1:0]   held_data_i,
  input  logic [DATA_WIDTH-1:0]   head_data_i,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic [DATA_WIDTH/8-1:0] strb_o
);
  always_comb begin
    data_o = '0;
    strb_o = '0;
    if (head_i) begin
      data_o = head_data_i;
      strb_o = '1;
    end else if (held_i) begin
      data_o = held_data_i;
      strb_o = '1;
    end
  end
endmodule

module axis_write_data_strb #(
  parameter int BUF_AWIDTH     = 9,
  parameter int CFG_DWIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int WIDTH_RATIO    = 2,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_LEN_WIDTH  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CFG_DWIDTH-1:0]       cfg_length,
  input  logic [AXI_LEN_WIDTH-1:0]    cfg_burst,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  output logic [AXI_DATA_WIDTH-1:0]   axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb,
  output logic                        axi_wlast,
  output logic                        axi_wvalid,
  input  logic                        axi_wready,
  input  logic [DATA_WIDTH-1:0]       data,
  input  logic                        valid,
  output logic                        ready,
`ifdef AXIS_WRITE_DATA_STRB_STATUS_EN
  output logic [CFG_DWIDTH-1:0]       beat_count,
  output logic [CFG_DWIDTH-1:0]       burst_count,
`endif
  output logic                        done
);
  localparam int DEPTH  = 2**BUF_AWIDTH;
  localparam int HALF   = DEPTH / 2;
  localparam int LANE_W = (WIDTH_RATIO > 1) ? $clog2(WIDTH_RATIO) : 1;
  localparam int STRB_W = AXI_DATA_WIDTH / 8;

  typedef enum logic [3:0] {
    IDLE   = 4'b0001,
    ACTIVE = 4'b0010,
    WAIT   = 4'b0100,
    DONE   = 4'b1000
  } state_e;

  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0]    mem_q [DEPTH];
  logic [BUF_AWIDTH-1:0]    wr_ptr_q, rd_ptr_q;
  logic [BUF_AWIDTH:0]      cnt_q, cnt_d;
  logic [CFG_DWIDTH-1:0]    len_q, len_d, in_cnt_q, in_cnt_d, pop_cnt_q;
  logic [AXI_LEN_WIDTH-1:0] burst_q, bcnt_q;
  logic [LANE_W-1:0]        lane_q;
  logic [WIDTH_RATIO-1:0][DATA_WIDTH-1:0]   held_q, lane_data;
  logic [WIDTH_RATIO-1:0][DATA_WIDTH/8-1:0] lane_strb;
  logic [AXI_DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]         wstrb_q;
  logic ready_q, ready_d, wvalid_q, wlast_q, final_q, done_q;
  logic [DATA_WIDTH-1:0] head;
  logic push, pop, out_free, last_word, beat_end, wlast_d, fin_hs, cfg_hs;

  assign head      = mem_q[rd_ptr_q];
  assign cfg_hs    = (state_q == IDLE) && cfg_valid;
  assign push      = valid && ready_q;
  // The output register must be free (or draining) before any lane is consumed.
  assign out_free  = !wvalid_q || axi_wready;
  assign pop       = (state_q == ACTIVE) && (cnt_q != '0) && out_free;
  assign last_word = (pop_cnt_q == len_q - CFG_DWIDTH'(1));
  assign beat_end  = pop && ((lane_q == LANE_W'(WIDTH_RATIO-1)) || last_word);
  assign wlast_d   = (bcnt_q == burst_q) || last_word;
  assign fin_hs    = wvalid_q && axi_wready && final_q;

  for (genvar g = 0; g < WIDTH_RATIO; g++) begin : g_lane
    axis_write_data_strb_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .held_i      (LANE_W'(g) < lane_q),
      .head_i      (LANE_W'(g) == lane_q),
      .held_data_i (held_q[g]),
      .head_data_i (head),
      .data_o      (lane_data[g]),
      .strb_o      (lane_strb[g])
    );
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cfg_valid) state_d = (cfg_length == '0) ? DONE : ACTIVE;
      ACTIVE:  if (pop && last_word) state_d = WAIT;
      WAIT:    if (fin_hs) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ready is registered, so it is computed from next-cycle occupancy and word count.
  always_comb begin
    cnt_d    = cnt_q + {{BUF_AWIDTH{1'b0}}, push} - {{BUF_AWIDTH{1'b0}}, pop};
    len_d    = cfg_hs ? cfg_length : len_q;
    in_cnt_d = cfg_hs ? '0 : in_cnt_q + CFG_DWIDTH'(push);
    ready_d  = (state_d == ACTIVE) && (cnt_d < (BUF_AWIDTH+1)'(HALF)) && (in_cnt_d < len_d);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      in_cnt_q  <= '0;
      pop_cnt_q <= '0;
      burst_q   <= '0;
      bcnt_q    <= '0;
      lane_q    <= '0;
      held_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wvalid_q  <= 1'b0;
      wlast_q   <= 1'b0;
      final_q   <= 1'b0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      in_cnt_q <= in_cnt_d;
      ready_q  <= ready_d;
      done_q   <= (state_d == DONE);
      if (push) wr_ptr_q <= wr_ptr_q + BUF_AWIDTH'(1);
      if (cfg_hs) begin
        burst_q   <= cfg_burst;
        pop_cnt_q <= '0;
        lane_q    <= '0;
        bcnt_q    <= '0;
      end
      if (pop) begin
        rd_ptr_q       <= rd_ptr_q + BUF_AWIDTH'(1);
        pop_cnt_q      <= pop_cnt_q + CFG_DWIDTH'(1);
        held_q[lane_q] <= head;
        lane_q         <= beat_end ? '0 : lane_q + LANE_W'(1);
      end
      if (beat_end) begin
        wvalid_q <= 1'b1;
        wdata_q  <= lane_data;
        wstrb_q  <= lane_strb;
        wlast_q  <= wlast_d;
        final_q  <= last_word;
        bcnt_q   <= wlast_d ? '0 : bcnt_q + AXI_LEN_WIDTH'(1);
      end else if (axi_wready) begin
        wvalid_q <= 1'b0;
        wlast_q  <= 1'b0;
        final_q  <= 1'b0;
      end
    end
  end

`ifdef AXIS_WRITE_DATA_STRB_STATUS_EN
  logic [CFG_DWIDTH-1:0] beat_cnt_q, burst_cnt_q;
  always_ff @(posedge clk) begin
    if (rst || cfg_hs) begin
      beat_cnt_q  <= '0;
      burst_cnt_q <= '0;
    end else if (wvalid_q && axi_wready) begin
      beat_cnt_q  <= beat_cnt_q + CFG_DWIDTH'(1);
      if (wlast_q) burst_cnt_q <= burst_cnt_q + CFG_DWIDTH'(1);
    end
  end
  assign beat_count  = beat_cnt_q;
  assign burst_count = burst_cnt_q;
`endif

  assign cfg_ready  = (state_q == IDLE);
  assign ready      = ready_q;
  assign axi_wvalid = wvalid_q;
  assign axi_wdata  = wdata_q;
  assign axi_wstrb  = wstrb_q;
  assign axi_wlast  = wlast_q;
  assign done       = done_q;
endmodule

// File: tb/tb_axis_write_data_strb.sv
// Bench for axis_write_data_strb: vector table + random transfers against a beat-level reference model.
module tb_axis_write_data_strb;
  localparam int AW = 3, CW = 32, DW = 32, WR = 2, ADW = 64, LW = 8;
  localparam int HALF = (2**AW) / 2;

  logic clk = 1'b0;
  logic rst;
  logic [CW-1:0]  cfg_length;
  logic [LW-1:0]  cfg_burst;
  logic           cfg_valid, cfg_ready;
  logic [ADW-1:0] axi_wdata;
  logic [7:0]     axi_wstrb;
  logic           axi_wlast, axi_wvalid, axi_wready;
  logic [DW-1:0]  data;
  logic           valid, ready, done;
`ifdef AXIS_WRITE_DATA_STRB_STATUS_EN
  logic [CW-1:0]  beat_count, burst_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axis_write_data_strb #(
    .BUF_AWIDTH(AW), .CFG_DWIDTH(CW), .DATA_WIDTH(DW), .WIDTH_RATIO(WR),
    .AXI_DATA_WIDTH(ADW), .AXI_LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_length(cfg_length), .cfg_burst(cfg_burst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .data(data), .valid(valid), .ready(ready),
`ifdef AXIS_WRITE_DATA_STRB_STATUS_EN
    .beat_count(beat_count), .burst_count(burst_count),
`endif
    .done(done)
  );

  typedef struct {
    int len;
    int burst;
    int wmode;     // 0: wready=1, 1: stalled then 1-in-3, 2: random
    int vmode;     // 0: valid=1, 1: random valid (3/4)
    int exp_beats;
    int exp_lasts;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Runs one transfer; abort_after>0 returns right after that many beat handshakes.
  task automatic run_xfer(input int len, input int burst, input int wmode, input int vmode,
                          input int exp_beats, input int exp_lasts, input int abort_after);
    logic [DW-1:0]  words [$];
    logic [ADW-1:0] e_data [$];
    logic [7:0]     e_strb [$];
    logic           e_last [$];
    logic [ADW-1:0] d, p_data;
    logic [7:0]     s, p_strb;
    logic           p_last, hold_prev, got_final, done_seen, spurious, overrun, overfill, stall_seen;
    logic           bad_hold;
    int nb, acc, bk, lasts, cyc;
    nb = (len + WR - 1) / WR;
    for (int i = 0; i < len; i++) words.push_back($urandom);
    for (int b = 0; b < nb; b++) begin
      d = '0;
      s = '0;
      for (int l = 0; l < WR; l++)
        if (b*WR + l < len) begin
          d[l*DW +: DW] = words[b*WR + l];
          s[l*4 +: 4]   = 4'hF;
        end
      e_data.push_back(d);
      e_strb.push_back(s);
      e_last.push_back(((b % (burst + 1)) == burst) || (b == nb - 1));
    end

    @(negedge clk);
    cyc = 0;
    while (!cfg_ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("cfg_ready_idle", cfg_ready, 1'b1);
    cfg_length = len;
    cfg_burst  = burst;
    cfg_valid  = 1'b1;
    @(negedge clk);
    cfg_valid  = 1'b0;

    acc = 0; bk = 0; lasts = 0;
    hold_prev = 0; got_final = 0; done_seen = 0; spurious = 0;
    overrun = 0; overfill = 0; stall_seen = 0; bad_hold = 0;
    p_data = '0; p_strb = '0; p_last = 0;
    for (cyc = 0; cyc < 3000; cyc++) begin
      if (got_final) begin
        chk("done_after_final", done, 1'b1);
        done_seen = 1;
        break;
      end
      if (done) spurious = 1;
      if (hold_prev && (!axi_wvalid || axi_wdata !== p_data || axi_wstrb !== p_strb ||
                        axi_wlast !== p_last)) bad_hold = 1;
      if (ready && acc >= len) overrun = 1;
      if (acc - WR*bk > HALF + 2*WR - 1) overfill = 1;
      if (!ready && acc > 0 && acc < len) stall_seen = 1;

      case (wmode)
        0:       axi_wready = 1'b1;
        1:       axi_wready = (cyc >= 30) && (cyc % 3 == 0);
        default: axi_wready = 1'($urandom_range(0, 1));
      endcase
      valid      = (vmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      data       = (acc < len) ? words[acc] : $urandom;
      cfg_valid  = (!cfg_ready && vmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      cfg_length = $urandom_range(1, 9);

      if (valid && ready) acc++;
      if (axi_wvalid && axi_wready) begin
        if (bk < nb) begin
          chk($sformatf("wdata[%0d]", bk), axi_wdata, e_data[bk]);
          chk($sformatf("wstrb[%0d]", bk), {56'd0, axi_wstrb}, {56'd0, e_strb[bk]});
          chk($sformatf("wlast[%0d]", bk), {63'd0, axi_wlast}, {63'd0, e_last[bk]});
        end else begin
          chk("extra_beat", 64'(bk), 64'(nb - 1));
        end
        if (axi_wlast) lasts++;
        bk++;
        if (bk == nb) got_final = 1;
        if (abort_after > 0 && bk == abort_after) break;
      end
      hold_prev = axi_wvalid && !axi_wready;
      p_data = axi_wdata;
      p_strb = axi_wstrb;
      p_last = axi_wlast;
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    chk("wvalid_stable", bad_hold, 1'b0);
    chk("ready_after_length", overrun, 1'b0);
    chk("fifo_occupancy", overfill, 1'b0);
    if (abort_after > 0) return;

    chk("transfer_completes", done_seen, 1'b1);
    chk("no_early_done", spurious, 1'b0);
    chk("beat_total", 64'(bk), 64'(exp_beats));
    chk("wlast_total", 64'(lasts), 64'(exp_lasts));
    if (wmode == 1) chk("ready_throttles", stall_seen, 1'b1);
`ifdef AXIS_WRITE_DATA_STRB_STATUS_EN
    chk("beat_count", 64'(beat_count), 64'(exp_beats));
    chk("burst_count", 64'(burst_count), 64'(exp_lasts));
`endif
    valid      = 1'b0;
    axi_wready = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", done, 1'b0);
    chk("cfg_ready_after_done", cfg_ready, 1'b1);
    chk("no_beat_after_done", axi_wvalid, 1'b0);
  endtask

  initial begin
    int len, burst, nb;
    rst = 1'b1; cfg_length = '0; cfg_burst = '0; cfg_valid = 1'b0;
    axi_wready = 1'b0; data = '0; valid = 1'b0;
    tbl[0] = '{len: 8,  burst: 3, wmode: 0, vmode: 0, exp_beats: 4,  exp_lasts: 1};
    tbl[1] = '{len: 7,  burst: 3, wmode: 0, vmode: 0, exp_beats: 4,  exp_lasts: 1};
    tbl[2] = '{len: 20, burst: 3, wmode: 0, vmode: 0, exp_beats: 10, exp_lasts: 3};
    tbl[3] = '{len: 16, burst: 3, wmode: 1, vmode: 1, exp_beats: 8,  exp_lasts: 2};
    tbl[4] = '{len: 5,  burst: 0, wmode: 2, vmode: 1, exp_beats: 3,  exp_lasts: 3};
    tbl[5] = '{len: 1,  burst: 7, wmode: 2, vmode: 1, exp_beats: 1,  exp_lasts: 1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cfg_ready", cfg_ready, 1'b1);
    chk("rst_wvalid", axi_wvalid, 1'b0);
    chk("rst_wlast", axi_wlast, 1'b0);
    chk("rst_wstrb", {56'd0, axi_wstrb}, 64'd0);
    chk("rst_wdata", axi_wdata, 64'd0);
    chk("rst_ready", ready, 1'b0);
    chk("rst_done", done, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++)
      run_xfer(tbl[i].len, tbl[i].burst, tbl[i].wmode, tbl[i].vmode,
               tbl[i].exp_beats, tbl[i].exp_lasts, 0);

    for (int i = 0; i < 6; i++) begin
      len   = $urandom_range(1, 40);
      burst = $urandom_range(0, 5);
      nb    = (len + 1) / 2;
      run_xfer(len, burst, 2, 1, nb, nb / (burst + 1) + ((nb % (burst + 1)) != 0 ? 1 : 0), 0);
    end

    // Zero-length transfer: straight to done, no beats.
    @(negedge clk);
    axi_wready = 1'b1;
    cfg_length = '0; cfg_burst = 8'd3; cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("len0_done", done, 1'b1);
    chk("len0_wvalid", axi_wvalid, 1'b0);
    chk("len0_cfg_busy", cfg_ready, 1'b0);
    @(negedge clk);
    chk("len0_done_clear", done, 1'b0);
    chk("len0_cfg_ready", cfg_ready, 1'b1);
    chk("len0_wvalid_after", axi_wvalid, 1'b0);

    // Reset after beat 2 of a 16-word transfer, then a fresh 4-word transfer.
    run_xfer(16, 3, 0, 0, 8, 2, 2);
    @(negedge clk);
    rst = 1'b1;
    valid = 1'b1;
    axi_wready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_wvalid", axi_wvalid, 1'b0);
    chk("abort_ready", ready, 1'b0);
    chk("abort_cfg_ready", cfg_ready, 1'b1);
    repeat (3) @(negedge clk);
    chk("abort_no_beats", axi_wvalid, 1'b0);
    valid = 1'b0;
    run_xfer(4, 1, 0, 0, 2, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
